// File: rtl/missile_pkg.sv
// ---------------------------------------------------------------
// missile_pkg : shared types and helpers for the missile pool
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package missile_pkg;

  localparam int MAX_MISSILE = 8;

  typedef enum logic {
    CD_IDLE = 1'b0,
    CD_COOL = 1'b1
  } cd_state_t;

  // Lowest index whose valid bit is clear; callers pad unused channels with ones.
  function automatic logic [2:0] lowest_free(input logic [MAX_MISSILE-1:0] valid);
    lowest_free = '0;
    for (int i = MAX_MISSILE - 1; i >= 0; i--) begin
      if (!valid[i]) lowest_free = 3'(i);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/missile_slot.sv
// ---------------------------------------------------------------
// missile_slot : one missile channel (load, move, retire, hit)
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module missile_slot #(
  parameter int COORD_W = 10,
  parameter int STEP    = 4,
  parameter int Y_TOP   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  logic               tick_move,
  input  logic               hit,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               valid,
  output logic               hit_eff
);

  localparam logic [COORD_W-1:0] Y_LIM  = COORD_W'(Y_TOP + STEP);
  localparam logic [COORD_W-1:0] STEP_V = COORD_W'(STEP);

  // A freshly loaded channel is never valid yet, but gate explicitly anyway.
  assign hit_eff = hit & valid & ~load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x     <= '0;
      y     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      x     <= load_x;
      y     <= load_y;
      valid <= 1'b1;
    end else if (hit_eff) begin
      valid <= 1'b0;
    end else if (tick_move && valid) begin
      if (y >= Y_LIM) y <= y - STEP_V;
      else            valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/missile_pool.sv
// ---------------------------------------------------------------
// missile_pool : N-channel missile launcher with shared cooldown
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module missile_pool
  import missile_pkg::*;
#(
  parameter int N_MISSILE = 4,
  parameter int COORD_W   = 10,
  parameter int STEP      = 4,
  parameter int Y_TOP     = 0,
  parameter int CD_TICKS  = 2,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick_move,
  input  logic                         tick_sec,
  input  logic                         shoot,
  input  logic [COORD_W-1:0]           r_x,
  input  logic [COORD_W-1:0]           r_y,
  input  logic [N_MISSILE-1:0]         hit,
  output logic [N_MISSILE*COORD_W-1:0] m_x,
  output logic [N_MISSILE*COORD_W-1:0] m_y,
  output logic [N_MISSILE-1:0]         m_valid,
  output logic                         cd_busy,
  output logic                         fire_ack,
  output logic                         fire_drop,
  output logic [CNT_W-1:0]             hit_count
);

  localparam int CD_W = (CD_TICKS < 2) ? 1 : $clog2(CD_TICKS + 1);
  localparam logic [CD_W-1:0]    CD_LOAD = CD_W'(CD_TICKS);
  localparam logic [CNT_W+3:0]   CNT_MAX = {4'b0000, {CNT_W{1'b1}}};

  logic                   shoot_d;
  logic                   fire_req;
  logic                   any_free;
  logic                   accept;
  logic [MAX_MISSILE-1:0] valid_pad;
  logic [2:0]             free_idx;
  logic [N_MISSILE-1:0]   load;
  logic [N_MISSILE-1:0]   hit_eff;
  logic [3:0]             hit_pop;
  logic [CNT_W+3:0]       hit_sum;
  cd_state_t              state, state_nxt;
  logic [CD_W-1:0]        cd_cnt, cd_cnt_nxt;

  assign fire_req = shoot & ~shoot_d;
  assign any_free = ~&m_valid;
  assign accept   = fire_req && (state == CD_IDLE) && any_free;
  assign cd_busy  = (state == CD_COOL);

  always_comb begin
    valid_pad = '1;
    valid_pad[N_MISSILE-1:0] = m_valid;
    free_idx = lowest_free(valid_pad);
  end

  always_comb begin
    load = '0;
    for (int i = 0; i < N_MISSILE; i++) begin
      load[i] = accept && (free_idx == 3'(i));
    end
  end

  generate
    for (genvar g = 0; g < N_MISSILE; g++) begin : g_slot
      missile_slot #(
        .COORD_W (COORD_W),
        .STEP    (STEP),
        .Y_TOP   (Y_TOP)
      ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load[g]),
        .load_x    (r_x),
        .load_y    (r_y),
        .tick_move (tick_move),
        .hit       (hit[g]),
        .x         (m_x[g*COORD_W +: COORD_W]),
        .y         (m_y[g*COORD_W +: COORD_W]),
        .valid     (m_valid[g]),
        .hit_eff   (hit_eff[g])
      );
    end
  endgenerate

  always_comb begin
    state_nxt  = state;
    cd_cnt_nxt = cd_cnt;
    case (state)
      CD_IDLE: begin
        // tick_sec is deliberately ignored here, including on the fire cycle
        if (accept) begin
          state_nxt  = CD_COOL;
          cd_cnt_nxt = CD_LOAD;
        end
      end
      CD_COOL: begin
        if (tick_sec) begin
          if (cd_cnt == CD_W'(1)) begin
            state_nxt  = CD_IDLE;
            cd_cnt_nxt = '0;
          end else begin
            cd_cnt_nxt = cd_cnt - CD_W'(1);
          end
        end
      end
      default: begin
        state_nxt  = CD_IDLE;
        cd_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    hit_pop = '0;
    for (int i = 0; i < N_MISSILE; i++) begin
      hit_pop = hit_pop + {3'b000, hit_eff[i]};
    end
    hit_sum = (CNT_W+4)'(hit_count) + (CNT_W+4)'(hit_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shoot_d   <= 1'b0;
      fire_ack  <= 1'b0;
      fire_drop <= 1'b0;
      state     <= CD_IDLE;
      cd_cnt    <= '0;
      hit_count <= '0;
    end else begin
      shoot_d   <= shoot;
      fire_ack  <= accept;
      fire_drop <= fire_req & ~accept;
      state     <= state_nxt;
      cd_cnt    <= cd_cnt_nxt;
      hit_count <= (hit_sum > CNT_MAX) ? {CNT_W{1'b1}} : hit_sum[CNT_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_missile_pool.sv
// ---------------------------------------------------------------
// tb_missile_pool : directed scoreboard bench for missile_pool
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_missile_pool;

  localparam int N  = 4;
  localparam int CW = 10;
  localparam int HW = 3;  // narrow counter so saturation is reachable

  typedef struct {
    int          kind;   // 0 probe, 1 ack, 2 drop
    logic [N-1:0] valid;
    logic        busy;
    logic [HW-1:0] hc;
    int          ch;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            tick_move = 1'b0;
  logic            tick_sec = 1'b0;
  logic            shoot = 1'b0;
  logic [CW-1:0]   r_x = '0;
  logic [CW-1:0]   r_y = '0;
  logic [N-1:0]    hit = '0;
  logic [N*CW-1:0] m_x;
  logic [N*CW-1:0] m_y;
  logic [N-1:0]    m_valid;
  logic            cd_busy;
  logic            fire_ack;
  logic            fire_drop;
  logic [HW-1:0]   hit_count;
  logic            probe = 1'b0;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  missile_pool #(
    .N_MISSILE (N),
    .COORD_W   (CW),
    .STEP      (4),
    .Y_TOP     (0),
    .CD_TICKS  (2),
    .CNT_W     (HW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_move (tick_move),
    .tick_sec  (tick_sec),
    .shoot     (shoot),
    .r_x       (r_x),
    .r_y       (r_y),
    .hit       (hit),
    .m_x       (m_x),
    .m_y       (m_y),
    .m_valid   (m_valid),
    .cd_busy   (cd_busy),
    .fire_ack  (fire_ack),
    .fire_drop (fire_drop),
    .hit_count (hit_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "timeout");
  end

  // Monitor: pops one expectation per observed event or probe strobe.
  always @(negedge clk) begin
    if (fire_ack || fire_drop || probe) begin
      int         k;
      exp_t       e;
      logic [CW-1:0] ax, ay;
      k = fire_ack ? 1 : (fire_drop ? 2 : 0);
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: kind %0d seen, none expected", k);
      end else begin
        e = q.pop_front();
        n_vec++;
        ax = m_x[e.ch*CW +: CW];
        ay = m_y[e.ch*CW +: CW];
        if (k != e.kind) begin
          n_fail++;
          $display("FAIL kind #%0d: got %0d want %0d", n_vec, k, e.kind);
        end
        if (m_valid !== e.valid) begin
          n_fail++;
          $display("FAIL m_valid #%0d: got %b want %b", n_vec, m_valid, e.valid);
        end
        if (cd_busy !== e.busy) begin
          n_fail++;
          $display("FAIL cd_busy #%0d: got %b want %b", n_vec, cd_busy, e.busy);
        end
        if (hit_count !== e.hc) begin
          n_fail++;
          $display("FAIL hit_count #%0d: got %0d want %0d", n_vec, hit_count, e.hc);
        end
        if (ax !== e.x || ay !== e.y) begin
          n_fail++;
          $display("FAIL ch%0d_pos #%0d: got (%0d,%0d) want (%0d,%0d)",
                   e.ch, n_vec, ax, ay, e.x, e.y);
        end
      end
    end
  end

  task automatic expect_ev(input int kind, input logic [N-1:0] v, input logic b,
                           input logic [HW-1:0] hc, input int ch,
                           input int x, input int y);
    exp_t e;
    e.kind = kind; e.valid = v; e.busy = b; e.hc = hc;
    e.ch = ch; e.x = CW'(x); e.y = CW'(y);
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_now(input logic [N-1:0] v, input logic b,
                           input logic [HW-1:0] hc, input int ch,
                           input int x, input int y);
    expect_ev(0, v, b, hc, ch, x, y);
    probe = 1'b1;
    @(negedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic press(input int x, input int y, input int kind, input logic [N-1:0] v,
                       input logic b, input logic [HW-1:0] hc, input int ch,
                       input int ex, input int ey);
    r_x = CW'(x);
    r_y = CW'(y);
    shoot = 1'b1;
    expect_ev(kind, v, b, hc, ch, ex, ey);
    step();
    shoot = 1'b0;
    step();
  endtask

  task automatic sec();
    tick_sec = 1'b1; step(); tick_sec = 1'b0;
  endtask

  task automatic move();
    tick_move = 1'b1; step(); tick_move = 1'b0;
  endtask

  task automatic hit_p(input logic [N-1:0] h);
    hit = h; step(); hit = '0;
  endtask

  initial begin
    repeat (3) step();
    check_now(4'b0000, 1'b0, 3'd0, 0, 0, 0);
    rst = 1'b1;
    step();

    // Launch and cooldown
    press(100, 400, 1, 4'b0001, 1'b1, 3'd0, 0, 100, 400);
    sec();
    check_now(4'b0001, 1'b1, 3'd0, 0, 100, 400);
    sec();
    check_now(4'b0001, 1'b0, 3'd0, 0, 100, 400);

    // Movement and top retirement
    repeat (5) move();
    check_now(4'b0001, 1'b0, 3'd0, 0, 100, 380);
    press(50, 6, 1, 4'b0011, 1'b1, 3'd0, 1, 50, 6);
    move();
    check_now(4'b0011, 1'b1, 3'd0, 1, 50, 2);
    move();
    check_now(4'b0001, 1'b1, 3'd0, 1, 50, 2);
    check_now(4'b0001, 1'b1, 3'd0, 0, 100, 372);
    sec(); sec();

    // Fill the pool, then a press with no free slot
    press(10, 20, 1, 4'b0011, 1'b1, 3'd0, 1, 10, 20);
    sec(); sec();
    press(30, 40, 1, 4'b0111, 1'b1, 3'd0, 2, 30, 40);
    sec(); sec();
    press(60, 70, 1, 4'b1111, 1'b1, 3'd0, 3, 60, 70);
    sec(); sec();
    press(200, 200, 2, 4'b1111, 1'b0, 3'd0, 0, 100, 372);

    // Press during cooldown, then held button
    hit_p(4'b1000);
    check_now(4'b0111, 1'b0, 3'd1, 3, 60, 70);
    press(5, 300, 1, 4'b1111, 1'b1, 3'd1, 3, 5, 300);
    hit_p(4'b0010);
    press(9, 9, 2, 4'b1101, 1'b1, 3'd2, 1, 10, 20);
    sec(); sec();
    r_x = CW'(7); r_y = CW'(8);
    shoot = 1'b1;
    expect_ev(1, 4'b1111, 1'b1, 3'd2, 1, 7, 8);
    repeat (10) step();
    shoot = 1'b0;
    step();
    sec(); sec();

    // Hit has priority over move; hit on an idle channel is ignored
    hit = 4'b0101; tick_move = 1'b1;
    step();
    hit = '0; tick_move = 1'b0;
    check_now(4'b1010, 1'b0, 3'd4, 0, 100, 372);
    check_now(4'b1010, 1'b0, 3'd4, 2, 30, 40);
    check_now(4'b1010, 1'b0, 3'd4, 1, 7, 4);
    hit_p(4'b0001);
    check_now(4'b1010, 1'b0, 3'd4, 3, 5, 296);

    // Counter saturation
    hit_p(4'b1010);
    check_now(4'b0000, 1'b0, 3'd6, 0, 100, 372);
    press(1, 1, 1, 4'b0001, 1'b1, 3'd6, 0, 1, 1);
    hit_p(4'b0001);
    sec(); sec();
    press(2, 2, 1, 4'b0001, 1'b1, 3'd7, 0, 2, 2);
    hit_p(4'b0001);
    check_now(4'b0000, 1'b1, 3'd7, 0, 2, 2);
    sec(); sec();

    // Reset mid-cooldown with three active missiles
    press(11, 12, 1, 4'b0001, 1'b1, 3'd7, 0, 11, 12);
    sec(); sec();
    press(13, 14, 1, 4'b0011, 1'b1, 3'd7, 1, 13, 14);
    sec(); sec();
    press(15, 16, 1, 4'b0111, 1'b1, 3'd7, 2, 15, 16);
    rst = 1'b0;
    check_now(4'b0000, 1'b0, 3'd0, 2, 0, 0);
    step();
    rst = 1'b1;
    step();
    press(9, 9, 1, 4'b0001, 1'b1, 3'd0, 0, 9, 9);

    repeat (3) step();
    if (q.size() != 0) begin
      $display("FAIL pending: got %0d unconsumed expectations, want 0", q.size());
      n_fail += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
